l2min2_filter_mc: RTL and testbench

Multi-channel, runtime-configurable reconstruction filter for incremental delta-sigma ADCs (IDCs). Accumulates 1-bit modulator bitstreams over an N-sample conversion with selectable weighting: CoI1, CoI2 or L2min2.
- Fully synchronous: no gated or derived clocks.
- Sits between CH parallel modulators and the readout/decimation interface.
- Uses a start/valid handshake and supports back-to-back conversions.

---
 rtl/l2min2_pkg.sv | 28 ++
 rtl/l2min2_filter_mc_weight_gen.sv | 59 +++++
 rtl/l2min2_filter_mc.sv | 122 ++++++++++++
 tb/tb_l2min2_filter_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/l2min2_pkg.sv
// Shared mode encodings, FSM state type and width helpers for the
// incremental delta-sigma reconstruction filter.
package l2min2_pkg;

    localparam logic [1:0] MODE_COI1   = 2'd0;
    localparam logic [1:0] MODE_COI2   = 2'd1;
    localparam logic [1:0] MODE_L2MIN2 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int n_w_of(input int log2_nmax);
        return log2_nmax + 1;
    endfunction

    function automatic int wgt_w_of(input int log2_nmax);
        return 2 * log2_nmax;
    endfunction

    function automatic int out_w_of(input int log2_nmax);
        return 3 * log2_nmax - 1;
    endfunction

endpackage

// File: rtl/l2min2_filter_mc_weight_gen.sv
// Shared weight sequence generator: sample index k, current weight w and
// the last-sample flag, stepped by load/advance strobes from the top FSM.
module l2min2_weight_gen
    import l2min2_pkg::*;
#(
    parameter int LOG2_NMAX = 10,
    parameter int N_W       = n_w_of(LOG2_NMAX),
    parameter int WGT_W     = wgt_w_of(LOG2_NMAX)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             load,
    input  logic             advance,
    input  logic [N_W-1:0]   n_val,
    input  logic [1:0]       mode,
    output logic [WGT_W-1:0] w,
    output logic             last
);

    // N*(N+1) needs one bit more than S itself
    localparam int P_W = WGT_W + 1;

    logic [N_W-1:0]   k;
    logic [P_W-1:0]   prod;
    logic [WGT_W-1:0] s_val;
    logic [WGT_W-1:0] w_init;

    assign prod  = P_W'(n_val) * P_W'(n_val + N_W'(1));
    assign s_val = WGT_W'(prod >> 1);
    assign last  = (k == n_val - N_W'(1));

    always_comb begin
        w_init = WGT_W'(1);
        case (mode)
            MODE_COI2:   w_init = WGT_W'(n_val);
            MODE_L2MIN2: w_init = s_val;
            default:     w_init = WGT_W'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            k <= '0;
            w <= '0;
        end else if (load) begin
            k <= '0;
            w <= w_init;
        end else if (advance) begin
            k <= k + N_W'(1);
            // L2min2 steps by the pre-increment k: S, S, S-1, S-3, ...
            case (mode)
                MODE_COI2:   w <= w - WGT_W'(1);
                MODE_L2MIN2: w <= w - WGT_W'(k);
                default:     w <= w;
            endcase
        end
    end

endmodule

// File: rtl/l2min2_filter_mc.sv
// Multi-channel CoI1/CoI2/L2min2 reconstruction filter for incremental
// delta-sigma ADCs: control FSM plus one weighted accumulator per channel.
module l2min2_filter_mc
    import l2min2_pkg::*;
#(
    parameter int LOG2_NMAX = 10,
    parameter int CH        = 4,
    parameter int N_W       = n_w_of(LOG2_NMAX),
    parameter int WGT_W     = wgt_w_of(LOG2_NMAX),
    parameter int OUT_W     = out_w_of(LOG2_NMAX)
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                start,
    input  logic [N_W-1:0]      N_in,
    input  logic [1:0]          mode_in,
    input  logic [CH-1:0]       d_in,
    input  logic                d_valid,
    output logic                busy,
    output logic [CH*OUT_W-1:0] d_out,
    output logic                out_valid,
    output logic                err
);

    localparam logic [N_W-1:0] NMAX = N_W'(1) << LOG2_NMAX;

    state_t           state, state_nxt;
    logic [N_W-1:0]   n_r;
    logic [1:0]       mode_r;
    logic [WGT_W-1:0] w;
    logic             last;
    logic             load_stb;
    logic             adv_stb;
    logic             start_window;
    logic             cfg_ok;
    logic [OUT_W-1:0] acc   [CH];
    logic [OUT_W-1:0] res_r [CH];

    function automatic logic cfg_legal(input logic [N_W-1:0] n, input logic [1:0] m);
        return (n >= N_W'(2)) && (n <= NMAX) && (m != 2'd3);
    endfunction

    assign cfg_ok       = cfg_legal(N_in, mode_in);
    assign start_window = (state == ST_IDLE) || (state == ST_DONE);
    assign load_stb     = (state == ST_LOAD);
    assign adv_stb      = (state == ST_RUN) && d_valid;
    assign busy         = (state == ST_LOAD) || (state == ST_RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && cfg_ok) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  if (adv_stb && last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = (start && cfg_ok) ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= ST_IDLE;
            n_r    <= '0;
            mode_r <= MODE_COI1;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_window && start) begin
                err <= !cfg_ok;
                if (cfg_ok) begin
                    n_r    <= N_in;
                    mode_r <= mode_in;
                end
            end
        end
    end

    l2min2_weight_gen #(
        .LOG2_NMAX (LOG2_NMAX),
        .N_W       (N_W),
        .WGT_W     (WGT_W)
    ) u_weight_gen (
        .clk     (clk),
        .rstb    (rstb),
        .load    (load_stb),
        .advance (adv_stb),
        .n_val   (n_r),
        .mode    (mode_r),
        .w       (w),
        .last    (last)
    );

    // accumulate stage: all channels share the same weight this sample
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int c = 0; c < CH; c++) acc[c] <= '0;
        end else if (load_stb) begin
            for (int c = 0; c < CH; c++) acc[c] <= '0;
        end else if (adv_stb) begin
            for (int c = 0; c < CH; c++)
                acc[c] <= acc[c] + (d_in[c] ? OUT_W'(w) : OUT_W'(0));
        end
    end

    // output stage: result and its strobe are registered together in DONE
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid <= 1'b0;
            for (int c = 0; c < CH; c++) res_r[c] <= '0;
        end else begin
            out_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                for (int c = 0; c < CH; c++) res_r[c] <= acc[c];
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_dout
        assign d_out[c*OUT_W +: OUT_W] = res_r[c];
    end

endmodule

// File: tb/tb_l2min2_filter_mc.sv
// Directed, table-driven bench for l2min2_filter_mc with hand-computed results.
module tb_l2min2_filter_mc;

    localparam int LOG2_NMAX = 10;
    localparam int CH        = 4;
    localparam int N_W       = 11;
    localparam int OUT_W     = 29;

    localparam logic [1:0] M_COI1 = 2'd0;
    localparam logic [1:0] M_COI2 = 2'd1;
    localparam logic [1:0] M_L2   = 2'd2;

    logic                clk = 1'b0;
    logic                rstb;
    logic                start;
    logic [N_W-1:0]      N_in;
    logic [1:0]          mode_in;
    logic [CH-1:0]       d_in;
    logic                d_valid;
    logic                busy;
    logic [CH*OUT_W-1:0] d_out;
    logic                out_valid;
    logic                err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]                 mode;
        int                         n;
        logic [CH-1:0][15:0]        pat;
        logic [CH-1:0][OUT_W-1:0]   expv;
    } vec_t;

    vec_t vecs [8];

    l2min2_filter_mc #(.LOG2_NMAX(LOG2_NMAX), .CH(CH)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .start     (start),
        .N_in      (N_in),
        .mode_in   (mode_in),
        .d_in      (d_in),
        .d_valid   (d_valid),
        .busy      (busy),
        .d_out     (d_out),
        .out_valid (out_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, expv);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input int n);
        @(negedge clk);
        start   = 1'b1;
        mode_in = m;
        N_in    = N_W'(n);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic feed(input int n, input logic [CH-1:0][15:0] pat, input logic [15:0] gap_mask);
        for (int k = 0; k < n; k++) begin
            if (k < 16 && gap_mask[k]) begin
                @(negedge clk);
                d_valid = 1'b0;
                d_in    = CH'($urandom);
            end
            @(negedge clk);
            d_valid = 1'b1;
            for (int c = 0; c < CH; c++) d_in[c] = pat[c][k % 16];
        end
        @(negedge clk);
        d_valid = 1'b0;
        d_in    = '0;
    endtask

    // Entered on the falling edge right after the last sample was consumed.
    task automatic wait_result(input string name, input logic [CH-1:0][OUT_W-1:0] expv);
        int pulses = 0;
        bit seen   = 1'b0;
        chk({name, "_early_ov"}, 64'(out_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (!seen) begin
                    seen = 1'b1;
                    for (int c = 0; c < CH; c++)
                        chk($sformatf("%s_ch%0d", name, c),
                            64'(d_out[c*OUT_W +: OUT_W]), 64'(expv[c]));
                end
            end
        end
        chk({name, "_pulses"}, 64'(pulses), 64'd1);
    endtask

    task automatic illegal_start(input string name, input logic [1:0] m, input int n);
        bit ov_seen = 1'b0;
        bit bz_seen = 1'b0;
        do_start(m, n);
        chk({name, "_err"}, 64'(err), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
            if (busy) bz_seen = 1'b1;
        end
        chk({name, "_busy"}, 64'(bz_seen), 64'd0);
        chk({name, "_ov"}, 64'(ov_seen), 64'd0);
    endtask

    initial begin
        logic [15:0] gmask;

        vecs[0] = '{M_L2,   4,  {16'h000F, 16'h000F, 16'h000F, 16'h000F}, {29'd36, 29'd36, 29'd36, 29'd36}};
        vecs[1] = '{M_COI2, 4,  {16'h0000, 16'h000F, 16'h0000, 16'h0000}, {29'd0, 29'd10, 29'd0, 29'd0}};
        vecs[2] = '{M_COI1, 8,  {16'h0000, 16'h0000, 16'h0000, 16'h0055}, {29'd0, 29'd0, 29'd0, 29'd4}};
        vecs[3] = '{M_L2,   4,  {16'h0008, 16'h0000, 16'h0000, 16'h0000}, {29'd7, 29'd0, 29'd0, 29'd0}};
        vecs[4] = '{M_L2,   2,  {16'h0000, 16'h0000, 16'h0002, 16'h0003}, {29'd0, 29'd0, 29'd3, 29'd6}};
        vecs[5] = '{M_COI2, 5,  {16'h0000, 16'h0000, 16'h0011, 16'h001F}, {29'd0, 29'd0, 29'd6, 29'd15}};
        vecs[6] = '{M_L2,   6,  {16'h0004, 16'h0020, 16'h0000, 16'h003F}, {29'd20, 29'd11, 29'd0, 29'd106}};
        vecs[7] = '{M_COI1, 16, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, {29'd16, 29'd16, 29'd16, 29'd16}};

        rstb    = 1'b0;
        start   = 1'b0;
        N_in    = '0;
        mode_in = '0;
        d_in    = '0;
        d_valid = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_dout", 64'(d_out != '0), 64'd0);
        @(negedge clk);
        rstb = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_start(vecs[i].mode, vecs[i].n);
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            feed(vecs[i].n, vecs[i].pat, 16'h0000);
            wait_result($sformatf("vec%0d", i), vecs[i].expv);
        end

        // Back-to-back: start is raised while the filter sits in DONE.
        do_start(M_COI2, 4);
        feed(4, {16'h0000, 16'h000F, 16'h0000, 16'h0000}, 16'h0000);
        start   = 1'b1;
        mode_in = M_COI1;
        N_in    = N_W'(8);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_ov", 64'(out_valid), 64'd1);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_first_ch2", 64'(d_out[2*OUT_W +: OUT_W]), 64'd10);
        feed(8, {16'h0000, 16'h0000, 16'h0000, 16'h0055}, 16'h0000);
        wait_result("b2b_second", {29'd0, 29'd0, 29'd0, 29'd4});

        // Three stall cycles interleaved among the four samples.
        gmask = 16'h000F & ~(16'h0001 << $urandom_range(0, 3));
        do_start(M_L2, 4);
        feed(4, {16'h0008, 16'h0000, 16'h0000, 16'h0000}, gmask);
        wait_result("gaps", {29'd7, 29'd0, 29'd0, 29'd0});

        // Longest conversion, exercising the full accumulator width.
        do_start(M_L2, 1024);
        chk("n1024_err", 64'(err), 64'd0);
        feed(1024, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'h0000);
        wait_result("n1024", {29'd0, 29'd0, 29'd0, 29'd358962176});

        illegal_start("ill_n0", M_L2, 0);
        illegal_start("ill_n1025", M_L2, 1025);
        illegal_start("ill_mode3", 2'd3, 8);
        do_start(M_L2, 4);
        chk("err_clear", 64'(err), 64'd0);
        feed(4, {16'h000F, 16'h000F, 16'h000F, 16'h000F}, 16'h0000);
        wait_result("after_err", {29'd36, 29'd36, 29'd36, 29'd36});

        // Reset in the middle of an N=16 conversion.
        do_start(M_L2, 16);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d_valid = 1'b1;
            d_in    = '1;
        end
        @(negedge clk);
        d_valid = 1'b0;
        rstb    = 1'b0;
        #1;
        chk("midrst_dout", 64'(d_out != '0), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ov", 64'(out_valid), 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        do_start(M_L2, 16);
        feed(16, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'h0000);
        wait_result("restart", {29'd0, 29'd0, 29'd0, 29'd1616});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
